// File: rtl/ciaa_kbd_serial_tx.sv
// Serialises Amiga raw key codes onto a KCLK/KDAT keyboard link with handshake, resync and power-up codes.
// Optional reset-warning sequence (kbdrst input) is built when CIAA_KBD_RESETWARN_EN is defined.
module ciaa_kbd_serial_tx #(
    parameter int unsigned TPHASE      = 142,
    parameter int unsigned THS_TIMEOUT = 1014000
`ifdef CIAA_KBD_RESETWARN_EN
   ,parameter int unsigned TRST_HOLD   = 3546000
`endif
) (
    input  logic       clk,
    input  logic       clk7_en,
    input  logic       reset,
    input  logic [7:0] keydat,
    input  logic       keystrobe,
`ifdef CIAA_KBD_RESETWARN_EN
    input  logic       kbdrst,
`endif
    output logic       keyack,
    input  logic       kdat_i,
    output logic       kclk_o,
    output logic       kdat_o,
    output logic       busy
);

    typedef enum logic [2:0] {
        PWRUP,
        IDLE,
        SHIFT,
        WAIT_HS,
        WAIT_REL,
        RESYNC,
        RETRY
`ifdef CIAA_KBD_RESETWARN_EN
       ,HOLD
`endif
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_LOW,
        PH_HIGH
    } phase_t;

    localparam logic [21:0] TIMER_MAX  = '1;
    localparam logic [21:0] PHASE_LAST = 22'(TPHASE - 1);
    localparam logic [21:0] HS_LIMIT   = 22'(THS_TIMEOUT);
`ifdef CIAA_KBD_RESETWARN_EN
    localparam logic [21:0] HOLD_LAST  = 22'(TRST_HOLD - 1);
`endif

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [21:0] timer_q, timer_d;
    logic [7:0]  tx_code_q, tx_code_d;
    logic [7:0]  retry_code_q, retry_code_d;
    logic [1:0]  pwr_cnt_q, pwr_cnt_d;
    logic        resync_q, resync_d;
    logic        retry_q, retry_d;
    logic        keyack_q, keyack_d;
    logic        kdat_meta, kdat_sync;
    logic        start_frame;
    logic        phase_done;
    logic        hold_low;
    logic [7:0]  pwr_code;
    logic [7:0]  line_byte;

`ifdef CIAA_KBD_RESETWARN_EN
    logic        kbdrst_meta, kbdrst_sync, kbdrst_prev;
    logic        kbdrst_rise;
    logic        rw_req_q, rw_req_d;
    logic [1:0]  rw_stage_q, rw_stage_d;

    assign kbdrst_rise = kbdrst_sync & ~kbdrst_prev;
    assign hold_low    = (state_q == HOLD);
`else
    assign hold_low    = 1'b0;
`endif

    assign phase_done = (timer_q == PHASE_LAST);
    assign pwr_code   = (pwr_cnt_q == 2'd2) ? 8'hFD : 8'hFE;
    // Line sees the code rotated left by one and inverted: a logical 1 pulls KDAT low.
    assign line_byte  = ~{tx_code_q[6:0], tx_code_q[7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PWRUP;
            phase_q      <= PH_SETUP;
            bit_q        <= '0;
            timer_q      <= '0;
            tx_code_q    <= '0;
            retry_code_q <= '0;
            pwr_cnt_q    <= 2'd2;
            resync_q     <= 1'b0;
            retry_q      <= 1'b0;
            keyack_q     <= 1'b0;
            kdat_meta    <= 1'b1;
            kdat_sync    <= 1'b1;
`ifdef CIAA_KBD_RESETWARN_EN
            kbdrst_meta  <= 1'b0;
            kbdrst_sync  <= 1'b0;
            kbdrst_prev  <= 1'b0;
            rw_req_q     <= 1'b0;
            rw_stage_q   <= '0;
`endif
        end else if (clk7_en) begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            timer_q      <= timer_d;
            tx_code_q    <= tx_code_d;
            retry_code_q <= retry_code_d;
            pwr_cnt_q    <= pwr_cnt_d;
            resync_q     <= resync_d;
            retry_q      <= retry_d;
            keyack_q     <= keyack_d;
            kdat_meta    <= kdat_i;
            kdat_sync    <= kdat_meta;
`ifdef CIAA_KBD_RESETWARN_EN
            kbdrst_meta  <= kbdrst;
            kbdrst_sync  <= kbdrst_meta;
            kbdrst_prev  <= kbdrst_sync;
            rw_req_q     <= rw_req_d;
            rw_stage_q   <= rw_stage_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        timer_d      = (timer_q == TIMER_MAX) ? timer_q : timer_q + 22'd1;
        tx_code_d    = tx_code_q;
        retry_code_d = retry_code_q;
        pwr_cnt_d    = pwr_cnt_q;
        resync_d     = resync_q;
        retry_d      = retry_q;
        keyack_d     = 1'b0;
        start_frame  = 1'b0;
`ifdef CIAA_KBD_RESETWARN_EN
        rw_req_d     = rw_req_q | kbdrst_rise;
        rw_stage_d   = rw_stage_q;
`endif

        case (state_q)
            PWRUP: begin
                tx_code_d    = pwr_code;
                retry_code_d = pwr_code;
                if (pwr_cnt_q != 2'd0) pwr_cnt_d = pwr_cnt_q - 2'd1;
                start_frame  = 1'b1;
            end

            IDLE: begin
`ifdef CIAA_KBD_RESETWARN_EN
                if (rw_req_q) begin
                    tx_code_d   = 8'h78;
                    rw_stage_d  = 2'd1;
                    rw_req_d    = 1'b0;
                    start_frame = 1'b1;
                end else
`endif
                if (keystrobe) begin
                    keyack_d     = 1'b1;
                    tx_code_d    = keydat;
                    retry_code_d = keydat;
                    start_frame  = 1'b1;
                end
            end

            // RESYNC reuses the bit sequencer for a single bit driven low.
            SHIFT, RESYNC: begin
                if (phase_done) begin
                    timer_d = '0;
                    case (phase_q)
                        PH_SETUP: phase_d = PH_LOW;
                        PH_LOW:   phase_d = PH_HIGH;
                        default: begin
                            phase_d = PH_SETUP;
                            if (state_q == RESYNC || bit_q == 3'd0) begin
                                state_d = WAIT_HS;
                                if (state_q == RESYNC) resync_d = 1'b1;
                            end else begin
                                bit_d = bit_q - 3'd1;
                            end
                        end
                    endcase
                end
            end

            WAIT_HS: begin
                if (!kdat_sync) begin
                    state_d = WAIT_REL;
                end else if (timer_q == HS_LIMIT) begin
`ifdef CIAA_KBD_RESETWARN_EN
                    if (rw_stage_q != 2'd0) begin
                        state_d = WAIT_REL;
                    end else
`endif
                    begin
                        state_d = RESYNC;
                        phase_d = PH_SETUP;
                        timer_d = '0;
                    end
                end
            end

            // Lost-sync report precedes the retry, which precedes any remaining power-up code.
            WAIT_REL: begin
                if (kdat_sync) begin
`ifdef CIAA_KBD_RESETWARN_EN
                    if (rw_stage_q == 2'd1) begin
                        tx_code_d   = 8'h78;
                        rw_stage_d  = 2'd2;
                        start_frame = 1'b1;
                    end else if (rw_stage_q == 2'd2) begin
                        rw_stage_d  = 2'd0;
                        state_d     = HOLD;
                        timer_d     = '0;
                    end else
`endif
                    if (resync_q) begin
                        tx_code_d   = 8'hF9;
                        resync_d    = 1'b0;
                        retry_d     = 1'b1;
                        start_frame = 1'b1;
                    end else if (retry_q) begin
                        state_d = RETRY;
                    end else if (pwr_cnt_q != 2'd0) begin
                        state_d = PWRUP;
                    end
`ifdef CIAA_KBD_RESETWARN_EN
                    else if (rw_req_q) begin
                        tx_code_d   = 8'h78;
                        rw_stage_d  = 2'd1;
                        rw_req_d    = 1'b0;
                        start_frame = 1'b1;
                    end
`endif
                    else begin
                        state_d = IDLE;
                    end
                end
            end

            RETRY: begin
                tx_code_d   = retry_code_q;
                retry_d     = 1'b0;
                start_frame = 1'b1;
            end

`ifdef CIAA_KBD_RESETWARN_EN
            HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    state_d   = PWRUP;
                    pwr_cnt_d = 2'd2;
                    resync_d  = 1'b0;
                    retry_d   = 1'b0;
                    rw_req_d  = 1'b0;
                end
            end
`endif

            default: state_d = PWRUP;
        endcase

        if (start_frame) begin
            state_d = SHIFT;
            phase_d = PH_SETUP;
            bit_d   = 3'd7;
            timer_d = '0;
        end
    end

    assign keyack = keyack_q;
    assign busy   = (state_q != IDLE);
    assign kclk_o = !(((state_q == SHIFT) || (state_q == RESYNC)) && (phase_q == PH_LOW)) && !hold_low;
    assign kdat_o = (state_q == RESYNC) ? 1'b0 :
                    (state_q == SHIFT)  ? line_byte[bit_q] : 1'b1;

endmodule

// File: tb/tb_ciaa_kbd_serial_tx.sv
// Directed bench for ciaa_kbd_serial_tx: framing, power-up codes, handshake, resync/retry and reset abort.
module tb_ciaa_kbd_serial_tx;

    localparam int unsigned TPH = 4;
    localparam int unsigned THS = 300;

    logic       clk = 1'b0;
    logic       clk7_en = 1'b1;
    logic       reset = 1'b1;
    logic [7:0] keydat = 8'h00;
    logic       keystrobe = 1'b0;
    logic       kdat_i = 1'b1;
    logic       keyack, kclk_o, kdat_o, busy;
`ifdef CIAA_KBD_RESETWARN_EN
    logic       kbdrst = 1'b0;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic        bits_q[$];
    int unsigned low_lens[$];
    int unsigned low_run = 0;
    int unsigned ack_cnt = 0;
    int unsigned cyc = 0;
    logic        prev_kclk = 1'b1;
    logic        prev_ack = 1'b0;
    bit          half_rate = 1'b0;

    always #5 clk = ~clk;

    ciaa_kbd_serial_tx #(
        .TPHASE(TPH),
        .THS_TIMEOUT(THS)
`ifdef CIAA_KBD_RESETWARN_EN
       ,.TRST_HOLD(64)
`endif
    ) dut (
        .clk(clk),
        .clk7_en(clk7_en),
        .reset(reset),
        .keydat(keydat),
        .keystrobe(keystrobe),
`ifdef CIAA_KBD_RESETWARN_EN
        .kbdrst(kbdrst),
`endif
        .keyack(keyack),
        .kdat_i(kdat_i),
        .kclk_o(kclk_o),
        .kdat_o(kdat_o),
        .busy(busy)
    );

    // Line monitor: captures KDAT at each KCLK fall, KCLK low lengths and keyack pulses.
    always @(negedge clk) begin
        cyc++;
        if (prev_kclk === 1'b1 && kclk_o === 1'b0) bits_q.push_back(kdat_o);
        if (kclk_o === 1'b0) begin
            low_run++;
        end else begin
            if (prev_kclk === 1'b0) low_lens.push_back(low_run);
            low_run = 0;
        end
        if (keyack === 1'b1 && prev_ack !== 1'b1) ack_cnt++;
        prev_kclk = kclk_o;
        prev_ack  = keyack;
        clk7_en   = half_rate ? ~clk7_en : 1'b1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic get_bits(input int n, output logic [7:0] b);
        int t = 0;
        b = '0;
        while (bits_q.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (bits_q.size() < n) b = 'x;
        else for (int i = 0; i < n; i++) b = {b[6:0], bits_q.pop_front()};
    endtask

    task automatic wait_kclk_high();
        int t = 0;
        while (kclk_o !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_ack(input int unsigned target);
        int t = 0;
        while (ack_cnt < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic handshake();
        wait_kclk_high();
        wait_cycles(2);
        kdat_i = 1'b0;
        wait_cycles(20);
        kdat_i = 1'b1;
        wait_cycles(8);
    endtask

    task automatic test_reset();
        wait_cycles(3);
        checks++; if (kclk_o !== 1'b1) begin errors++; $display("FAIL reset_kclk: got %b required 1", kclk_o); end
        checks++; if (kdat_o !== 1'b1) begin errors++; $display("FAIL reset_kdat: got %b required 1", kdat_o); end
        checks++; if (keyack !== 1'b0) begin errors++; $display("FAIL reset_keyack: got %b required 0", keyack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
    endtask

    task automatic test_powerup();
        logic [7:0] b;
        int unsigned bad;
        keydat = 8'h45;
        keystrobe = 1'b1;
        reset = 1'b0;
        get_bits(8, b);
        checks++; if (b !== 8'h04) begin errors++; $display("FAIL pwr_fd_frame: got %h required 04", b); end
        handshake();
        get_bits(8, b);
        checks++; if (b !== 8'h02) begin errors++; $display("FAIL pwr_fe_frame: got %h required 02", b); end
        checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL pwr_no_ack: got %0d acks required 0", ack_cnt); end
        handshake();
        wait_ack(1);
        keystrobe = 1'b0;
        checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL key45_ack: got %0d acks required 1", ack_cnt); end
        get_bits(8, b);
        checks++; if (b !== 8'h75) begin errors++; $display("FAIL key45_frame: got %h required 75", b); end
        wait_kclk_high();
        wait_cycles(2);
        bad = 0;
        if (low_lens.size() < 8) bad = 99;
        else for (int i = low_lens.size() - 8; i < low_lens.size(); i++) if (low_lens[i] != TPH) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL key45_lowlen: got %0d bad phases required 0", bad); end
        kdat_i = 1'b0;
        wait_cycles(12);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL key45_busy_hs: got %b required 1", busy); end
        kdat_i = 1'b1;
        wait_cycles(8);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL key45_busy_rel: got %b required 0", busy); end
    endtask

    task automatic test_upstroke();
        logic [7:0] b;
        int unsigned base = ack_cnt;
        keydat = 8'hC5;
        keystrobe = 1'b1;
        wait_ack(base + 1);
        keystrobe = 1'b0;
        get_bits(8, b);
        checks++; if (b !== 8'h74) begin errors++; $display("FAIL keyC5_frame: got %h required 74", b); end
        handshake();
        checks++; if (ack_cnt !== base + 1) begin errors++; $display("FAIL keyC5_ack: got %0d required %0d", ack_cnt, base + 1); end
    endtask

    task automatic test_no_handshake();
        logic [7:0] b;
        int unsigned base = ack_cnt;
        int unsigned t0, dt;
        keydat = 8'h45;
        keystrobe = 1'b1;
        wait_ack(base + 1);
        keystrobe = 1'b0;
        get_bits(8, b);
        checks++; if (b !== 8'h75) begin errors++; $display("FAIL nohs_first: got %h required 75", b); end
        wait_kclk_high();
        t0 = cyc;
        get_bits(1, b);
        dt = cyc - t0;
        checks++; if (b !== 8'h00) begin errors++; $display("FAIL resync_bit: got %h required 00", b); end
        checks++;
        if (dt < THS + 2 * TPH - 1 || dt > THS + 2 * TPH + 3) begin
            errors++; $display("FAIL resync_delay: got %0d cycles required %0d..%0d", dt, THS + 2 * TPH - 1, THS + 2 * TPH + 3);
        end
        handshake();
        get_bits(8, b);
        checks++; if (b !== 8'h0C) begin errors++; $display("FAIL lostsync_frame: got %h required 0C", b); end
        handshake();
        get_bits(8, b);
        checks++; if (b !== 8'h75) begin errors++; $display("FAIL retry_frame: got %h required 75", b); end
        handshake();
        checks++; if (ack_cnt !== base + 1) begin errors++; $display("FAIL retry_ack: got %0d required %0d", ack_cnt, base + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL retry_idle: got %b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int unsigned base = ack_cnt;
        keydat = 8'h45;
        keystrobe = 1'b1;
        wait_ack(base + 1);
        keydat = 8'hC5;
        get_bits(8, b);
        checks++; if (b !== 8'h75) begin errors++; $display("FAIL b2b_first: got %h required 75", b); end
        checks++; if (ack_cnt !== base + 1) begin errors++; $display("FAIL b2b_busy_ack: got %0d required %0d", ack_cnt, base + 1); end
        handshake();
        wait_ack(base + 2);
        keystrobe = 1'b0;
        get_bits(8, b);
        checks++; if (b !== 8'h74) begin errors++; $display("FAIL b2b_second: got %h required 74", b); end
        handshake();
        checks++; if (ack_cnt !== base + 2) begin errors++; $display("FAIL b2b_ack: got %0d required %0d", ack_cnt, base + 2); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int unsigned base = ack_cnt;
        keydat = 8'h45;
        keystrobe = 1'b1;
        wait_ack(base + 1);
        keystrobe = 1'b0;
        get_bits(5, b);
        wait_cycles(1);
        checks++; if (kdat_o !== 1'b0) begin errors++; $display("FAIL mid_bit3_kdat: got %b required 0", kdat_o); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (kclk_o !== 1'b1) begin errors++; $display("FAIL mid_reset_kclk: got %b required 1", kclk_o); end
        checks++; if (kdat_o !== 1'b1) begin errors++; $display("FAIL mid_reset_kdat: got %b required 1", kdat_o); end
        wait_cycles(2);
        reset = 1'b0;
        bits_q.delete();
        get_bits(8, b);
        checks++; if (b !== 8'h04) begin errors++; $display("FAIL mid_fd_frame: got %h required 04", b); end
        handshake();
        get_bits(8, b);
        checks++; if (b !== 8'h02) begin errors++; $display("FAIL mid_fe_frame: got %h required 02", b); end
        handshake();
    endtask

    task automatic test_half_rate();
        logic [7:0] b;
        int unsigned bad;
        int unsigned base = ack_cnt;
        half_rate = 1'b1;
        keydat = 8'hC5;
        keystrobe = 1'b1;
        wait_ack(base + 1);
        keystrobe = 1'b0;
        get_bits(8, b);
        checks++; if (b !== 8'h74) begin errors++; $display("FAIL half_frame: got %h required 74", b); end
        wait_kclk_high();
        wait_cycles(2);
        bad = 0;
        if (low_lens.size() < 8) bad = 99;
        else for (int i = low_lens.size() - 8; i < low_lens.size(); i++) if (low_lens[i] != 2 * TPH) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL half_lowlen: got %0d bad phases required 0", bad); end
        handshake();
        half_rate = 1'b0;
        wait_cycles(4);
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_upstroke();
        test_no_handshake();
        test_back_to_back();
        test_reset_midframe();
        test_half_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
